// File: rtl/sdram_pkg.sv
// Encodings shared between the SDRAM sequencing FSM and the command encoder.
package sdram_pkg;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_BST = 4'b0110;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [4:0] {
        I_200us    = 5'd0,
        I_pre      = 5'd1,
        I_wait_pre = 5'd2,
        I_refresh1 = 5'd3,  I_wait_re1 = 5'd4,
        I_refresh2 = 5'd5,  I_wait_re2 = 5'd6,
        I_refresh3 = 5'd7,  I_wait_re3 = 5'd8,
        I_refresh4 = 5'd9,  I_wait_re4 = 5'd10,
        I_refresh5 = 5'd11, I_wait_re5 = 5'd12,
        I_refresh6 = 5'd13, I_wait_re6 = 5'd14,
        I_refresh7 = 5'd15, I_wait_re7 = 5'd16,
        I_refresh8 = 5'd17, I_wait_re8 = 5'd18,
        I_mrs      = 5'd19,
        I_wati_mrs = 5'd20,
        I_done     = 5'd21
    } init_st_e;

    typedef enum logic [3:0] {
        W_IDLE   = 4'd0,
        W_ACTIVE = 4'd1,
        W_TRCD   = 4'd2,
        W_READ   = 4'd3,
        W_CL     = 4'd4,
        W_RDDAT  = 4'd5,
        W_WRITE  = 4'd6,
        W_BSTOP  = 4'd7,
        W_PRECH  = 4'd8,
        W_TRP    = 4'd9,
        W_REF    = 4'd10,
        W_RC     = 4'd11,
        W_CHGACT = 4'd12,
        W_TRPACT = 4'd13
    } work_st_e;

    localparam logic [2:0] SYS_IDLE = 3'd0;
    localparam logic [2:0] SYS_RD   = 3'd1;
    localparam logic [2:0] SYS_WR   = 3'd2;
    localparam logic [2:0] SYS_REF  = 3'd3;

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running auto-refresh interval counter with a sticky pending flag.
module sdram_ref_timer #(
    parameter int REF_INTV = 700
) (
    input  logic clk,
    input  logic rst,
    input  logic i_arm,
    input  logic i_clr,
    output logic o_pending
);

    localparam int CW = $clog2(REF_INTV);

    logic [CW-1:0] r_cnt;
    logic          r_pend;
    logic          w_wrap;

    assign w_wrap    = (r_cnt == CW'(REF_INTV - 1));
    assign o_pending = r_pend;

    // Wraps before the device is initialised are ignored: init issues its own refreshes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap && i_arm)
                r_pend <= 1'b1;
            else if (i_clr)
                r_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_state_ctrl.sv
// SDRAM sequencing FSM: power-up init, auto-refresh and read/write burst arbitration.
// Define SDRAM_RR_ARB_EN for round-robin rd/wr arbitration; default is fixed read priority.
module sdram_state_ctrl
    import sdram_pkg::*;
#(
    parameter int T_200US   = 20000,
    parameter int T_RP      = 2,
    parameter int T_RC      = 7,
    parameter int T_RCD     = 2,
    parameter int T_MRD     = 2,
    parameter int CAS_LAT   = 3,
    parameter int BURST_LEN = 512,
    parameter int REF_INTV  = 700
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_sdram_req,
    input  logic        rd_sdram_req,
    output logic [4:0]  init_st,
    output logic [4:0]  work_st,
    output logic [15:0] cnt_work,
    output logic [2:0]  sys_state,
    output logic        wr_ack,
    output logic        rd_ack,
    output logic        wr_data_req,
    output logic        rd_data_vld,
    output logic        wr_done,
    output logic        rd_done,
    output logic        init_done
);

    init_st_e    r_init_st, w_init_nxt;
    logic [15:0] r_cnt_init, w_init_dur;
    logic        w_init_done;

    work_st_e    r_work_st, w_ws_nxt;
    logic [15:0] r_cnt_work, w_work_dur;
    logic        w_work_last;
    logic [2:0]  r_sys_state, w_sys_nxt;
    logic        w_rd_gnt, w_wr_gnt, w_ref_gnt, w_pick_rd;
    logic        w_ref_pend;

    logic        r_rd_ack, r_wr_ack, r_rd_done, r_wr_done;
    logic        w_prech_entry;
    logic [CAS_LAT:0] r_vld_pipe;
    logic [15:0] r_vld_win;

    always_comb begin
        w_init_dur = 16'd1;
        case (r_init_st)
            I_200us:    w_init_dur = 16'(T_200US);
            I_wait_pre: w_init_dur = 16'(T_RP);
            I_wait_re1, I_wait_re2, I_wait_re3, I_wait_re4,
            I_wait_re5, I_wait_re6, I_wait_re7, I_wait_re8:
                        w_init_dur = 16'(T_RC);
            I_wati_mrs: w_init_dur = 16'(T_MRD);
            default:    w_init_dur = 16'd1;
        endcase
        w_init_nxt = r_init_st;
        // Init codes are consecutive, so each step is just the next code.
        if (r_init_st != I_done && r_cnt_init == w_init_dur - 16'd1)
            w_init_nxt = init_st_e'(r_init_st + 5'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_init_st  <= I_200us;
            r_cnt_init <= 16'd0;
        end else begin
            r_init_st  <= w_init_nxt;
            r_cnt_init <= (w_init_nxt != r_init_st || r_init_st == I_done) ? 16'd0
                                                                          : r_cnt_init + 16'd1;
        end
    end

    assign w_init_done = (r_init_st == I_done);

    sdram_ref_timer #(
        .REF_INTV (REF_INTV)
    ) u_ref_timer (
        .clk       (clk),
        .rst       (rst),
        .i_arm     (w_init_done),
        .i_clr     (w_ref_gnt),
        .o_pending (w_ref_pend)
    );

`ifdef SDRAM_RR_ARB_EN
    logic r_last_wr;

    // Reset as if a write went last, so the very first tie goes to the read path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_wr <= 1'b1;
        else if (w_rd_gnt)
            r_last_wr <= 1'b0;
        else if (w_wr_gnt)
            r_last_wr <= 1'b1;
    end

    assign w_pick_rd = rd_sdram_req && (!wr_sdram_req || r_last_wr);
`else
    assign w_pick_rd = rd_sdram_req;
`endif

    always_comb begin
        w_work_dur = 16'd1;
        case (r_work_st)
            W_TRCD:           w_work_dur = 16'(T_RCD);
            W_RDDAT, W_WRITE: w_work_dur = 16'(BURST_LEN);
            W_TRP:            w_work_dur = 16'(T_RP);
            W_RC:             w_work_dur = 16'(T_RC);
            default:          w_work_dur = 16'd1;
        endcase
    end

    assign w_work_last = (r_cnt_work == w_work_dur - 16'd1);

    always_comb begin
        w_ws_nxt  = r_work_st;
        w_sys_nxt = r_sys_state;
        w_rd_gnt  = 1'b0;
        w_wr_gnt  = 1'b0;
        w_ref_gnt = 1'b0;
        if (r_work_st == W_IDLE) begin
            w_sys_nxt = SYS_IDLE;
            if (w_init_done) begin
                if (w_ref_pend) begin
                    w_ws_nxt  = W_REF;
                    w_sys_nxt = SYS_REF;
                    w_ref_gnt = 1'b1;
                end else if (w_pick_rd) begin
                    w_ws_nxt  = W_ACTIVE;
                    w_sys_nxt = SYS_RD;
                    w_rd_gnt  = 1'b1;
                end else if (wr_sdram_req) begin
                    w_ws_nxt  = W_ACTIVE;
                    w_sys_nxt = SYS_WR;
                    w_wr_gnt  = 1'b1;
                end
            end
        end else if (w_work_last) begin
            case (r_work_st)
                W_ACTIVE: w_ws_nxt = W_TRCD;
                W_TRCD:   w_ws_nxt = (r_sys_state == SYS_RD) ? W_READ : W_WRITE;
                W_READ:   w_ws_nxt = W_RDDAT;
                W_RDDAT:  w_ws_nxt = W_PRECH;
                W_WRITE:  w_ws_nxt = W_BSTOP;
                W_BSTOP:  w_ws_nxt = W_PRECH;
                W_PRECH:  w_ws_nxt = W_TRP;
                W_REF:    w_ws_nxt = W_RC;
                default: begin
                    w_ws_nxt  = W_IDLE;
                    w_sys_nxt = SYS_IDLE;
                end
            endcase
        end
    end

    assign w_prech_entry = (w_ws_nxt == W_PRECH) && (r_work_st != W_PRECH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work_st   <= W_IDLE;
            r_cnt_work  <= 16'd0;
            r_sys_state <= SYS_IDLE;
            r_rd_ack    <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_rd_done   <= 1'b0;
            r_wr_done   <= 1'b0;
        end else begin
            r_work_st   <= w_ws_nxt;
            r_cnt_work  <= (w_ws_nxt != r_work_st) ? 16'd0 : r_cnt_work + 16'd1;
            r_sys_state <= w_sys_nxt;
            r_rd_ack    <= w_rd_gnt;
            r_wr_ack    <= w_wr_gnt;
            r_rd_done   <= w_prech_entry && (r_sys_state == SYS_RD);
            r_wr_done   <= w_prech_entry && (r_sys_state == SYS_WR);
        end
    end

    // One stage for the encoder register plus CAS_LAT, then a BURST_LEN-long window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_vld_win  <= 16'd0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[CAS_LAT-1:0], (r_work_st == W_READ)};
            if (r_vld_pipe[CAS_LAT])
                r_vld_win <= 16'(BURST_LEN - 1);
            else if (r_vld_win != 16'd0)
                r_vld_win <= r_vld_win - 16'd1;
        end
    end

    assign init_st     = r_init_st;
    assign init_done   = w_init_done;
    assign work_st     = {1'b0, r_work_st};
    assign cnt_work    = r_cnt_work;
    assign sys_state   = r_sys_state;
    assign rd_ack      = r_rd_ack;
    assign wr_ack      = r_wr_ack;
    assign rd_done     = r_rd_done;
    assign wr_done     = r_wr_done;
    assign wr_data_req = (r_work_st == W_WRITE);
    assign rd_data_vld = r_vld_pipe[CAS_LAT] || (r_vld_win != 16'd0);

endmodule

// File: tb/tb_sdram_state_ctrl.sv
// Scoreboard bench for sdram_state_ctrl: expected grants, state runs and read windows are queued per request.
module tb_sdram_state_ctrl;
    import sdram_pkg::*;

    localparam int BL = 512;

    typedef struct {
        logic [3:0] st;
        int         len;
    } run_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_sdram_req = 1'b0;
    logic        rd_sdram_req = 1'b0;
    logic [4:0]  init_st, work_st;
    logic [15:0] cnt_work;
    logic [2:0]  sys_state;
    logic        wr_ack, rd_ack, wr_data_req, rd_data_vld, wr_done, rd_done, init_done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    run_t       q_run[$];
    logic [2:0] q_grant[$];
    int         q_vld[$];

    sdram_state_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .wr_sdram_req (wr_sdram_req),
        .rd_sdram_req (rd_sdram_req),
        .init_st      (init_st),
        .work_st      (work_st),
        .cnt_work     (cnt_work),
        .sys_state    (sys_state),
        .wr_ack       (wr_ack),
        .rd_ack       (rd_ack),
        .wr_data_req  (wr_data_req),
        .rd_data_vld  (rd_data_vld),
        .wr_done      (wr_done),
        .rd_done      (rd_done),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic exp_run(input logic [3:0] st, input int len);
        run_t r;
        r.st  = st;
        r.len = len;
        q_run.push_back(r);
    endtask

    task automatic push_rd();
        q_grant.push_back(SYS_RD);
        exp_run(W_ACTIVE, 1); exp_run(W_TRCD, 2); exp_run(W_READ, 1);
        exp_run(W_RDDAT, BL); exp_run(W_PRECH, 1); exp_run(W_TRP, 2);
        q_vld.push_back(BL);
    endtask

    task automatic push_wr();
        q_grant.push_back(SYS_WR);
        exp_run(W_ACTIVE, 1); exp_run(W_TRCD, 2); exp_run(W_WRITE, BL);
        exp_run(W_BSTOP, 1); exp_run(W_PRECH, 1); exp_run(W_TRP, 2);
    endtask

    // Monitor: closes state runs, pops grants on acks, measures read-valid windows.
    initial begin
        logic [3:0] ws, m_ws;
        int   m_len, m_start, m_last, m_wrq, t_read, v_start;
        bit   v_prev;
        run_t r;
        logic [2:0] g;
        m_ws = W_IDLE; m_len = 0; m_start = 0; m_last = 0; m_wrq = 0;
        t_read = 0; v_start = 0; v_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ws = W_IDLE; m_len = 0; m_wrq = 0; v_prev = 1'b0;
            end else begin
                ws = work_st[3:0];
                if (wr_data_req) m_wrq++;
                if (ws != m_ws) begin
                    if (m_ws != W_IDLE) begin
                        chk("cnt_first", m_start, 0);
                        chk("cnt_last", m_last, m_len - 1);
                        if (m_ws == W_REF)
                            chk("ref_len", m_len, 1);
                        else if (m_ws == W_RC)
                            chk("rc_len", m_len, 7);
                        else if (q_run.size() == 0)
                            chk("run_extra", int'(m_ws), 0);
                        else begin
                            r = q_run.pop_front();
                            chk("run_st", int'(m_ws), int'(r.st));
                            chk("run_len", m_len, r.len);
                        end
                        if (m_ws == W_WRITE) begin
                            chk("wr_req_cycles", m_wrq, BL);
                            m_wrq = 0;
                        end
                    end
                    m_ws = ws; m_len = 1; m_start = int'(cnt_work);
                end else begin
                    m_len++;
                end
                m_last = int'(cnt_work);

                if (rd_ack || wr_ack) begin
                    if (q_grant.size() == 0)
                        chk("ack_extra", int'({rd_ack, wr_ack}), 0);
                    else begin
                        g = q_grant.pop_front();
                        chk("ack_kind", int'({rd_ack, wr_ack}), (g == SYS_RD) ? 2 : 1);
                        chk("ack_sys", int'(sys_state), int'(g));
                    end
                end

                if (ws == W_PRECH) begin
                    chk("wr_done", int'(wr_done), int'(sys_state == SYS_WR));
                    chk("rd_done", int'(rd_done), int'(sys_state == SYS_RD));
                end else if (wr_done || rd_done) begin
                    chk("done_stray", int'({wr_done, rd_done}), 0);
                end

                if (ws == W_READ) t_read = cyc;
                if (rd_data_vld && !v_prev) v_start = cyc;
                if (!rd_data_vld && v_prev) begin
                    if (q_vld.size() == 0)
                        chk("vld_extra", 1, 0);
                    else begin
                        chk("vld_delay", v_start - t_read, 4);
                        chk("vld_len", cyc - v_start, q_vld.pop_front());
                    end
                end
                v_prev = rd_data_vld;
            end
        end
    end

    task automatic run_init();
        int prev;
        bit seen;
        prev = 0;
        seen = 1'b0;
        chk("init_st_start", int'(init_st), 0);
        for (int i = 0; i < 21000 && !seen; i++) begin
            @(negedge clk);
            if (int'(init_st) != prev) begin
                chk("init_step", int'(init_st), prev + 1);
                if (init_st == 5'd1)  chk("t_pre", cyc, 20000);
                if (init_st == 5'd19) chk("t_mrs", cyc, 20067);
                prev = int'(init_st);
            end
            if (init_done) begin
                chk("t_init_done", cyc, 20070);
                chk("init_st_done", int'(init_st), 21);
                seen = 1'b1;
            end
        end
        if (!seen) chk("init_timeout", 0, 1);
    endtask

    task automatic drive(input int n_rd, input int n_wr);
        bit done;
        rd_sdram_req = (n_rd > 0);
        wr_sdram_req = (n_wr > 0);
        done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk);
            if (rd_ack && n_rd > 0) begin
                n_rd--;
                if (n_rd == 0) rd_sdram_req = 1'b0;
            end
            if (wr_ack && n_wr > 0) begin
                n_wr--;
                if (n_wr == 0) wr_sdram_req = 1'b0;
            end
            done = (n_rd == 0 && n_wr == 0);
        end
        if (!done) chk("ack_timeout", n_rd + n_wr, 0);
        rd_sdram_req = 1'b0;
        wr_sdram_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            done = (q_run.size() == 0 && q_grant.size() == 0 && work_st == 5'd0);
        end
        if (!done) chk("idle_timeout", q_run.size(), 0);
    endtask

    initial begin
        int nref, t1, t2;
        bit found;
        logic [3:0] p;

        repeat (3) @(negedge clk);
        chk("rst_init_st", int'(init_st), 0);
        chk("rst_work_st", int'(work_st), 0);
        chk("rst_cnt_work", int'(cnt_work), 0);
        chk("rst_sys_state", int'(sys_state), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_pulses", int'({wr_ack, rd_ack, wr_done, rd_done, rd_data_vld, wr_data_req}), 0);
        rst = 1'b0;
        run_init();

        // Idle refresh window right after init.
        nref = 0; t1 = 0; t2 = 0; p = W_IDLE;
        for (int i = 0; i < 1400; i++) begin
            @(negedge clk);
            if (work_st[3:0] == W_REF && p != W_REF) begin
                nref++;
                chk("ref_sys", int'(sys_state), 3);
                if (nref == 1) t1 = cyc;
                else           t2 = cyc;
            end
            p = work_st[3:0];
        end
        chk("ref_count", nref, 2);
        chk("ref_gap", t2 - t1, 700);

        push_rd();
        drive(1, 0);
        wait_idle();

        push_wr();
        drive(0, 1);
        wait_idle();

        // Tie: read kept requesting after its first grant to create a second tie.
`ifdef SDRAM_RR_ARB_EN
        push_rd(); push_wr(); push_rd();
`else
        push_rd(); push_rd(); push_wr();
`endif
        drive(2, 1);
        wait_idle();

        // Reset in the middle of a read burst.
        push_rd();
        drive(1, 0);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            found = (work_st[3:0] == W_RDDAT && cnt_work == 16'd100);
        end
        chk("rddat_100_seen", int'(found), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_init_st", int'(init_st), 0);
        chk("mid_rst_work_st", int'(work_st), 0);
        chk("mid_rst_cnt_work", int'(cnt_work), 0);
        chk("mid_rst_sys_state", int'(sys_state), 0);
        chk("mid_rst_rd_vld", int'(rd_data_vld), 0);
        chk("mid_rst_flags", int'({wr_ack, rd_ack, wr_done, rd_done, wr_data_req, init_done}), 0);
        q_run.delete();
        q_grant.delete();
        q_vld.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_init();

        chk("left_runs", q_run.size(), 0);
        chk("left_grants", q_grant.size(), 0);
        chk("left_vld", q_vld.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
